// File: rtl/hazard_issue_scheduler.sv
// Issue-stage hazard scheduler: EX/MEM writer scoreboard, RAW forward/stall decisions and mispredict flush.
// Optional macro HAZ_FWD_EN enables EX/MEM forwarding; without it every RAW match stalls until the writer leaves MEM.
module hazard_issue_scheduler #(
   parameter int RW        = 3,
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [RW-1:0]    rs1,
   input  logic [RW-1:0]    rs2,
   input  logic [RW-1:0]    rd,
   input  logic             rd_we,
   input  logic             is_load,
   input  logic             br_mispredict,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             pc_freeze,
   output logic             do_flush,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic          v;
      logic [RW-1:0] rd;
      logic          we;
      logic          ld;
   } ex_entry_t;

   // MEM results are always forwardable, so the load flag is not carried past EX.
   typedef struct packed {
      logic          v;
      logic [RW-1:0] rd;
      logic          we;
   } mem_entry_t;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYC);

   ex_entry_t  ex_q;
   mem_entry_t mem_q;
   state_t     state;
   logic [3:0] flush_cnt;

   logic ex_a, ex_b, mem_a, mem_b;
   logic hazard, transfer;
   logic [1:0] sel_a, sel_b;

   function automatic logic match(input logic [RW-1:0] s, input logic v, input logic we,
                                  input logic [RW-1:0] wr);
      return v & we & (wr == s) & (s != '0);
   endfunction

   assign ex_a  = match(rs1, ex_q.v, ex_q.we, ex_q.rd);
   assign ex_b  = match(rs2, ex_q.v, ex_q.we, ex_q.rd);
   assign mem_a = match(rs1, mem_q.v, mem_q.we, mem_q.rd);
   assign mem_b = match(rs2, mem_q.v, mem_q.we, mem_q.rd);

`ifdef HAZ_FWD_EN
   // Only a load still in EX cannot be forwarded; the EX result takes priority over MEM.
   assign hazard = (ex_a | ex_b) & ex_q.ld;
   assign sel_a  = ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
   assign sel_b  = ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
`else
   logic unused_ld;
   assign unused_ld = ex_q.ld;
   assign hazard    = ex_a | ex_b | mem_a | mem_b;
   assign sel_a     = 2'b00;
   assign sel_b     = 2'b00;
`endif

   // While in FLUSH the counter is always non-zero, so the state alone gates issue.
   assign issue_ready = rst_n & (state != FLUSH) & ~hazard;
   assign transfer    = issue_valid & issue_ready;
   assign do_flush    = rst_n & (state == FLUSH);
   assign pc_freeze   = rst_n & ((issue_valid & ~issue_ready) | (state == FLUSH));
   assign fwd_a       = transfer ? sel_a : 2'b00;
   assign fwd_b       = transfer ? sel_b : 2'b00;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         state       <= RUN;
         flush_cnt   <= '0;
         stall_count <= '0;
      end else begin
         mem_q <= '{v: ex_q.v, rd: ex_q.rd, we: ex_q.we};
         // A mispredict squashes whatever would enter EX at this edge.
         if (transfer && !br_mispredict)
            ex_q <= '{v: 1'b1, rd: rd, we: rd_we, ld: is_load};
         else
            ex_q <= '0;

         if (issue_valid && !issue_ready && !(&stall_count))
            stall_count <= stall_count + 1'b1;

         if (br_mispredict) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LD;
         end else begin
            case (state)
               FLUSH: begin
                  if (flush_cnt <= 4'd1) begin
                     state     <= RUN;
                     flush_cnt <= '0;
                  end else begin
                     flush_cnt <= flush_cnt - 4'd1;
                  end
               end
               default: state <= (hazard && issue_valid) ? STALL : RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hazard_issue_scheduler.sv
// Scoreboard bench for hazard_issue_scheduler: stimulus pushes expected operand selects, a negedge monitor pops on transfer.
// Expectations follow the HAZ_FWD_EN setting of the build.
module tb_hazard_issue_scheduler;

`ifdef HAZ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  rs1, rs2, rd;
   logic        rd_we, is_load, br_mispredict;
   logic [1:0]  fwd_a, fwd_b;
   logic        pc_freeze, do_flush;
   logic [15:0] stall_count;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_sc   = 0;

   hazard_issue_scheduler #(.RW(3), .FLUSH_CYC(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .is_load(is_load),
      .br_mispredict(br_mispredict), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pc_freeze(pc_freeze), .do_flush(do_flush), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every transfer must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (issue_valid && issue_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_transfer", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("fwd_a_id%0d", e.id), 32'(fwd_a), 32'(e.a));
            check($sformatf("fwd_b_id%0d", e.id), 32'(fwd_b), 32'(e.b));
         end
      end else begin
         check("fwd_idle_zero", 32'({fwd_a, fwd_b}), 32'd0);
      end
   end

   task automatic drive(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                        input logic we, input logic ld);
      rs1 = s1; rs2 = s2; rd = d; rd_we = we; is_load = ld;
      issue_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      issue_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                       input logic we, input logic ld, input int exp_st,
                       input logic [1:0] ea, input logic [1:0] eb);
      int  st;
      bit  ok;
      exp_q.push_back('{a: ea, b: eb, id: id});
      drive(s1, s2, d, we, ld);
      st = 0;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (issue_ready) begin
            ok = 1'b1;
            break;
         end
         st++;
         check($sformatf("pc_freeze_stall_id%0d", id), 32'(pc_freeze), 32'd1);
      end
      if (!ok) check($sformatf("accept_timeout_id%0d", id), 32'd0, 32'd1);
      check($sformatf("stall_cycles_id%0d", id), 32'(st), 32'(exp_st));
      exp_sc += exp_st;
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
      check($sformatf("stall_count_id%0d", id), 32'(stall_count), 32'(exp_sc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] flush_exp;
      rst_n = 1'b0; br_mispredict = 1'b0;
      drive(3'd0, 3'd0, 3'd0, 1'b0, 1'b0);

      // Reset holds issue off even with a valid instruction waiting.
      @(posedge clk); #1;
      repeat (3) begin
         @(negedge clk);
         check("rst_issue_ready", 32'(issue_ready), 32'd0);
         check("rst_do_flush", 32'(do_flush), 32'd0);
         check("rst_pc_freeze", 32'(pc_freeze), 32'd0);
         @(posedge clk); #1;
         check("rst_stall_count", 32'(stall_count), 32'd0);
      end
      rst_n = 1'b1;
      send(1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 2'b00, 2'b00);
      idle(2);

      // ALU producer rd=3 followed by two consumers.
      send(10, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 0, 2'b00, 2'b00);
      send(11, 3'd3, 3'd0, 3'd4, 1'b0, 1'b0, FWD ? 0 : 2, FWD ? 2'b01 : 2'b00, 2'b00);
      send(12, 3'd0, 3'd3, 3'd0, 1'b0, 1'b0, 0, 2'b00, FWD ? 2'b10 : 2'b00);
      idle(3);

      // Load-use on rs2.
      send(20, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 0, 2'b00, 2'b00);
      send(21, 3'd0, 3'd5, 3'd6, 1'b1, 1'b0, FWD ? 1 : 2, 2'b00, FWD ? 2'b10 : 2'b00);
      idle(3);

      // Writes to register 0 never create a dependency.
      send(30, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 0, 2'b00, 2'b00);
      send(31, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
      idle(3);

      // Mispredict together with issue of rd=3: the producer is squashed, a second pulse extends the flush.
      exp_q.push_back('{a: 2'b00, b: 2'b00, id: 40});
      drive(3'd0, 3'd0, 3'd3, 1'b1, 1'b0);
      br_mispredict = 1'b1;
      @(negedge clk);
      check("flush_t0_do_flush", 32'(do_flush), 32'd0);
      check("flush_t0_ready", 32'(issue_ready), 32'd1);
      @(posedge clk); #1;
      br_mispredict = 1'b0;
      exp_q.push_back('{a: 2'b00, b: 2'b00, id: 41});
      drive(3'd3, 3'd0, 3'd4, 1'b0, 1'b0);
      flush_exp = 5'b01111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("flush_do_flush_c%0d", i), 32'(do_flush), 32'(flush_exp[i]));
         check($sformatf("flush_ready_c%0d", i), 32'(issue_ready), 32'(!flush_exp[i]));
         check($sformatf("flush_pc_freeze_c%0d", i), 32'(pc_freeze), 32'(flush_exp[i]));
         @(posedge clk); #1;
         br_mispredict = (i == 0);
         if (i == 4) issue_valid = 1'b0;
      end
      exp_sc += 4;
      check("flush_stall_count", 32'(stall_count), 32'(exp_sc));
      idle(2);

      // Reset in the middle of a flush abandons it.
      br_mispredict = 1'b1;
      @(posedge clk); #1;
      br_mispredict = 1'b0;
      @(negedge clk);
      check("midflush_do_flush", 32'(do_flush), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midflush_rst_do_flush", 32'(do_flush), 32'd0);
      check("midflush_rst_ready", 32'(issue_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_sc = 0;
      @(negedge clk);
      check("post_rst_ready", 32'(issue_ready), 32'd1);
      check("post_rst_do_flush", 32'(do_flush), 32'd0);
      check("post_rst_pc_freeze", 32'(pc_freeze), 32'd0);
      check("post_rst_stall_count", 32'(stall_count), 32'd0);
      @(posedge clk); #1;
      send(50, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0, 0, 2'b00, 2'b00);
      idle(2);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
